// File: rtl/ibex_rvfi_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rvfi_trace_fifo
// Purpose  : Buffers RVFI retirement records and streams each as a fixed
//            packet of 32-bit words; counts records dropped on overflow.
//            Define IBEX_TRACE_MEM_EN to append memory-access words.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_rvfi_trace_fifo #(
  parameter int unsigned Depth    = 8,
  parameter int unsigned DropCntW = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       rvfi_valid_i,
  input  logic [63:0]                rvfi_order_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic                       rvfi_trap_i,
  input  logic                       rvfi_intr_i,
  input  logic [1:0]                 rvfi_mode_i,
  input  logic [4:0]                 rvfi_rd_addr_i,
  input  logic [31:0]                rvfi_rd_wdata_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_mem_addr_i,
  input  logic [3:0]                 rvfi_mem_rmask_i,
  input  logic [3:0]                 rvfi_mem_wmask_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_data_o,
  output logic                       trace_last_o,
  output logic [$clog2(Depth):0]     fifo_level_o,
  output logic [DropCntW-1:0]        drop_cnt_o
);

`ifdef IBEX_TRACE_MEM_EN
  localparam int unsigned NUM_WORDS = 6;
`else
  localparam int unsigned NUM_WORDS = 4;
`endif
  localparam int unsigned    PTR_W    = $clog2(Depth);
  localparam int unsigned    LVL_W    = PTR_W + 1;
  localparam int unsigned    IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(Depth);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DropCntW-1:0]   drop_cnt_q, drop_cnt_d;
  logic                  drop_pend_q, drop_pend_d;

  logic [31:0]           mem_q [Depth][NUM_WORDS];
  logic [31:0]           rec_w [NUM_WORDS];

  logic                  capture;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  unused_inputs;

`ifdef IBEX_TRACE_MEM_EN
  assign unused_inputs = ^rvfi_order_i[63:16];
`else
  assign unused_inputs = ^{rvfi_order_i[63:16], rvfi_mem_addr_i,
                           rvfi_mem_rmask_i, rvfi_mem_wmask_i};
`endif

  // Record is stored pre-formatted so the serialiser only has to index words.
  always_comb begin
    rec_w[0] = rvfi_pc_rdata_i;
    rec_w[1] = rvfi_insn_i;
    rec_w[2] = {rvfi_trap_i, rvfi_intr_i, rvfi_mode_i, rvfi_rd_addr_i,
                drop_pend_q, 6'b0, rvfi_order_i[15:0]};
    rec_w[3] = rvfi_rd_wdata_i;
`ifdef IBEX_TRACE_MEM_EN
    rec_w[4] = rvfi_mem_addr_i;
    rec_w[5] = {rvfi_mem_rmask_i, rvfi_mem_wmask_i, 24'b0};
`endif
  end

  assign trace_valid_o = (state_q == SEND);
  assign trace_last_o  = trace_valid_o && (idx_q == LAST_IDX);
  assign trace_data_o  = trace_valid_o ? mem_q[rd_ptr_q][idx_q] : 32'b0;

  // A full FIFO still accepts a record on the cycle its head leaves.
  assign pop     = trace_valid_o && trace_ready_i && trace_last_o;
  assign capture = rvfi_valid_i && enable_i;
  assign push    = capture && ((level_q < FULL_LVL) || pop);
  assign drop    = capture && !push;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    drop_pend_d = drop_pend_q;
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    if (push) begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(1);
      drop_pend_d = 1'b0;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (drop) begin
      drop_pend_d = 1'b1;
      if (drop_cnt_q != {DropCntW{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DropCntW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (trace_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (level_d != '0) ? SEND : IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      drop_cnt_q  <= '0;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_cnt_q  <= drop_cnt_d;
      drop_pend_q <= drop_pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem_q[wr_ptr_q][w] <= rec_w[w];
      end
    end
  end

  assign fifo_level_o = level_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_rvfi_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_rvfi_trace_fifo
// Purpose  : Scoreboard bench for ibex_rvfi_trace_fifo (honours IBEX_TRACE_MEM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_rvfi_trace_fifo;

`ifdef IBEX_TRACE_MEM_EN
  localparam int NW = 6;
`else
  localparam int NW = 4;
`endif

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i, enable_i, rvfi_valid_i, sat_valid_i;
  logic [63:0] rvfi_order_i;
  logic [31:0] rvfi_insn_i, rvfi_rd_wdata_i, rvfi_pc_rdata_i, rvfi_mem_addr_i;
  logic        rvfi_trap_i, rvfi_intr_i;
  logic [1:0]  rvfi_mode_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [3:0]  rvfi_mem_rmask_i, rvfi_mem_wmask_i;
  logic        trace_ready_i;
  logic        trace_valid_o, trace_last_o;
  logic [31:0] trace_data_o;
  logic [3:0]  fifo_level_o;
  logic [15:0] drop_cnt_o;
  logic        sat_tvalid, sat_tlast;
  logic [31:0] sat_tdata;
  logic [1:0]  sat_level;
  logic [3:0]  sat_drop;

  ibex_rvfi_trace_fifo #(.Depth(8), .DropCntW(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .rvfi_valid_i(rvfi_valid_i),
    .rvfi_order_i(rvfi_order_i), .rvfi_insn_i(rvfi_insn_i), .rvfi_trap_i(rvfi_trap_i),
    .rvfi_intr_i(rvfi_intr_i), .rvfi_mode_i(rvfi_mode_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
    .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
    .rvfi_mem_addr_i(rvfi_mem_addr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
    .rvfi_mem_wmask_i(rvfi_mem_wmask_i), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_data_o(trace_data_o), .trace_last_o(trace_last_o),
    .fifo_level_o(fifo_level_o), .drop_cnt_o(drop_cnt_o)
  );

  // Small instance used only to drive the drop counter into saturation.
  ibex_rvfi_trace_fifo #(.Depth(2), .DropCntW(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(1'b1), .rvfi_valid_i(sat_valid_i),
    .rvfi_order_i(rvfi_order_i), .rvfi_insn_i(rvfi_insn_i), .rvfi_trap_i(rvfi_trap_i),
    .rvfi_intr_i(rvfi_intr_i), .rvfi_mode_i(rvfi_mode_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
    .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
    .rvfi_mem_addr_i(rvfi_mem_addr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
    .rvfi_mem_wmask_i(rvfi_mem_wmask_i), .trace_valid_o(sat_tvalid),
    .trace_ready_i(1'b0), .trace_data_o(sat_tdata), .trace_last_o(sat_tlast),
    .fifo_level_o(sat_level), .drop_cnt_o(sat_drop)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] sb[$];
  logic        m_pend = 1'b0;
  logic [15:0] m_drop = 16'h0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one retirement for a cycle; acc says whether the FIFO must take it.
  task automatic drive_rec(input logic [31:0] pc, input logic [31:0] insn,
                           input logic [4:0] rd, input logic [31:0] wd,
                           input logic [63:0] order, input logic trap,
                           input logic intr, input logic [1:0] mode, input logic acc);
    logic [31:0] w [6];
    rvfi_valid_i = 1'b1;  rvfi_pc_rdata_i = pc;  rvfi_insn_i = insn;
    rvfi_rd_addr_i = rd;  rvfi_rd_wdata_i = wd; rvfi_order_i = order;
    rvfi_trap_i = trap;   rvfi_intr_i = intr;    rvfi_mode_i = mode;
    if (acc) begin
      w[0] = pc;
      w[1] = insn;
      w[2] = {trap, intr, mode, rd, m_pend, 6'b0, order[15:0]};
      w[3] = wd;
      w[4] = rvfi_mem_addr_i;
      w[5] = {rvfi_mem_rmask_i, rvfi_mem_wmask_i, 24'b0};
      m_pend = 1'b0;
      for (int i = 0; i < NW; i++) sb.push_back({(i == NW - 1), w[i]});
    end else begin
      m_pend = 1'b1;
      if (m_drop != 16'hFFFF) m_drop++;
    end
    tick();
    rvfi_valid_i = 1'b0;
  endtask

  task automatic rec_simple(input int n, input logic acc);
    logic [31:0] nv;
    nv = n;
    drive_rec(32'h8000_0000 + nv * 4, $urandom, nv[4:0], $urandom, {32'h0, nv},
              nv[0], nv[1], nv[3:2], acc);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    check("drain_empty", sb.size(), 0);
  endtask

  logic        prev_stall = 1'b0;
  logic        prev_last  = 1'b0;
  logic [31:0] prev_data  = 32'h0;

  always @(negedge clk_i) begin
    logic [32:0] e;
    if (!rst_i) begin
      if (prev_stall) begin
        check("hold_valid", trace_valid_o, 1);
        check("hold_data", trace_data_o, prev_data);
        check("hold_last", trace_last_o, prev_last);
      end
      if (trace_valid_o && trace_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_word", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("word_data", trace_data_o, e[31:0]);
          check("word_last", trace_last_o, e[32]);
        end
      end
    end
    prev_stall <= !rst_i && trace_valid_o && !trace_ready_i;
    prev_data  <= trace_data_o;
    prev_last  <= trace_last_o;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; rvfi_valid_i = 1'b0; sat_valid_i = 1'b0;
    rvfi_order_i = '0; rvfi_insn_i = '0; rvfi_rd_wdata_i = '0; rvfi_pc_rdata_i = '0;
    rvfi_trap_i = 1'b0; rvfi_intr_i = 1'b0; rvfi_mode_i = '0; rvfi_rd_addr_i = '0;
    rvfi_mem_addr_i = '0; rvfi_mem_rmask_i = '0; rvfi_mem_wmask_i = '0;
    trace_ready_i = 1'b1;
    repeat (3) tick();
    check("rst_valid", trace_valid_o, 0);
    check("rst_last", trace_last_o, 0);
    check("rst_data", trace_data_o, 0);
    check("rst_level", fifo_level_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    rst_i = 1'b0;
    tick();

    // Single record with first-word latency.
    drive_rec(32'h8000_0000, 32'h0050_0093, 5'd1, 32'h5, 64'd7, 1'b0, 1'b0, 2'd0, 1'b1);
    check("lat_valid_early", trace_valid_o, 0);
    check("lat_level", fifo_level_o, 1);
    tick();
    check("lat_valid", trace_valid_o, 1);
    wait_drain(NW + 2);
    check("idle_after_single", trace_valid_o, 0);

    // Backpressure on W1, then the remaining words with no bubble.
    rec_simple(2, 1'b1);
    tick();
    tick();
    trace_ready_i = 1'b0;
    repeat (5) tick();
    trace_ready_i = 1'b1;
    wait_drain(NW - 1);

    // Capture disabled: neither stored nor counted as dropped.
    enable_i = 1'b0; rvfi_valid_i = 1'b1;
    tick();
    rvfi_valid_i = 1'b0; enable_i = 1'b1;
    check("dis_level", fifo_level_o, 0);
    check("dis_drop", drop_cnt_o, m_drop);

    // Overflow: 10 records into 8 entries.
    trace_ready_i = 1'b0;
    for (int i = 1; i <= 10; i++) rec_simple(i, i <= 8);
    check("ovf_level", fifo_level_o, 8);
    check("ovf_drop", drop_cnt_o, m_drop);
    trace_ready_i = 1'b1;
    wait_drain(8 * NW + 4);
    check("ovf_idle", trace_valid_o, 0);
    rec_simple(11, 1'b1);
    rec_simple(12, 1'b1);
    wait_drain(2 * NW + 4);

    // Full FIFO with a push on the head's last-word handshake.
    trace_ready_i = 1'b0;
    for (int i = 20; i < 28; i++) rec_simple(i, 1'b1);
    check("full_level", fifo_level_o, 8);
    trace_ready_i = 1'b1;
    repeat (NW - 1) tick();
    rec_simple(30, 1'b1);
    trace_ready_i = 1'b0;
    check("coinc_level", fifo_level_o, 8);
    check("coinc_drop", drop_cnt_o, m_drop);
    trace_ready_i = 1'b1;
    wait_drain(8 * NW + 4);

    // Saturating drop counter on the narrow instance.
    sat_valid_i = 1'b1;
    repeat (7) tick();
    check("sat_drop_5", sat_drop, 5);
    repeat (15) tick();
    sat_valid_i = 1'b0;
    check("sat_drop_max", sat_drop, 4'hF);
    check("sat_level", sat_level, 2);

    // Memory-access fields (only part of the packet when the feature is built in).
    rvfi_mem_addr_i = 32'h0000_1000; rvfi_mem_wmask_i = 4'hF; rvfi_mem_rmask_i = 4'h0;
    rec_simple(35, 1'b1);
    wait_drain(NW + 4);
    rvfi_mem_addr_i = '0; rvfi_mem_wmask_i = '0;

    // Reset in the middle of a packet with more records queued.
    for (int i = 40; i < 43; i++) rec_simple(i, 1'b1);
    tick();
    rst_i = 1'b1;
    sb.delete();
    m_pend = 1'b0;
    m_drop = 16'h0;
    tick();
    check("mid_rst_valid", trace_valid_o, 0);
    check("mid_rst_last", trace_last_o, 0);
    check("mid_rst_data", trace_data_o, 0);
    check("mid_rst_level", fifo_level_o, 0);
    check("mid_rst_drop", drop_cnt_o, 0);
    check("mid_rst_sat_drop", sat_drop, 0);
    rst_i = 1'b0;
    tick();
    rec_simple(50, 1'b1);
    wait_drain(NW + 4);
    check("final_idle", trace_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
